// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the key debouncer
// Contents:
//   key_state_t     : debounce FSM state encoding
//   released_level  : raw pin level of an idle key for a given polarity
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    function automatic logic released_level(input logic active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// rtl/key_debouncer_if.sv - key pin and debounced outputs bundle
// Signals:
//   in    : raw, asynchronous, bouncing key pin (driven by the master side)
//   level : debounced key state, 1 = pressed
//   press : one-cycle pulse per accepted press (and per auto-repeat)
interface key_debouncer_if;
    logic in;
    logic level;
    logic press;

    modport master (output in, input level, input press);
    modport slave  (input in, output level, output press);
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer with parameterized reset value
// Ports:
//   clk   : sampling clock
//   rst   : synchronous active-high reset, loads RST_VAL into both flops
//   d     : asynchronous input
//   q     : synchronized output
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - pushbutton debouncer with press pulse and optional auto-repeat
// Ports:
//   Clock : sole clock, rising edge
//   Reset : synchronous active-high reset
//   key   : key_debouncer_if.slave (in -> level, press)
// Optional feature: define KEY_AUTOREPEAT_EN to emit repeat press pulses while held.
module key_debouncer
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input logic            Clock,
    input logic            Reset,
    key_debouncer_if.slave key
);
    localparam int MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CNT_W = $clog2(MAX_ALL) + 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic s2;
    logic raw;

    sync_2ff #(
        .RST_VAL(released_level(ACTIVE_LOW))
    ) u_sync (
        .clk(Clock),
        .rst(Reset),
        .d  (key.in),
        .q  (s2)
    );

    assign raw = ACTIVE_LOW ? ~s2 : s2;

    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rpt_fire;

    // cnt counts consecutive samples that disagree with the accepted level;
    // the >= compare stops it at DEB_LAST so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                if (raw) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!raw) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!raw) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (raw) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase

        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        // Only a fresh acceptance pulses; recovering from a release bounce does not.
        press_d = ((state_q == PRESS_WAIT) && (state_d == PRESSED)) || rpt_fire;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_q, rpt_d;
    logic             rpt_run_q, rpt_run_d;

    // rpt counts cycles spent staying in PRESSED since the last pulse; it is
    // frozen while a release bounce is being judged and restarts on a new press.
    always_comb begin
        rpt_d     = rpt_q;
        rpt_run_d = rpt_run_q;
        rpt_fire  = 1'b0;
        if ((state_q == PRESS_WAIT) || (state_d == RELEASED) || (state_d == PRESS_WAIT)) begin
            rpt_d     = '0;
            rpt_run_d = 1'b0;
        end else if ((state_q == PRESSED) && (state_d == PRESSED)) begin
            if (rpt_q >= (rpt_run_q ? PER_LAST : DLY_LAST)) begin
                rpt_fire  = 1'b1;
                rpt_d     = '0;
                rpt_run_d = 1'b1;
            end else begin
                rpt_d = rpt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rpt_q     <= '0;
            rpt_run_q <= 1'b0;
        end else begin
            rpt_q     <= rpt_d;
            rpt_run_q <= rpt_run_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign key.level = level_q;
    assign key.press = press_q;
endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - self-checking bench for key_debouncer
module tb_key_debouncer;
    localparam int DEB = 4;
    localparam int RDLY = 10;
    localparam int RPER = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    key_debouncer_if key_bus ();

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEB),
        .ACTIVE_LOW     (1'b1),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .key  (key_bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: the pin is seen two edges late; the accepted level flips
    // once DEB consecutive samples disagree with it; press marks a rise.
    logic m_s1, m_s2, m_lvl, m_prs, m_run;
    int   m_cnt, m_rpt;
    int   press_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic pin, input logic r);
        logic raw, prev_lvl;
        int   prev_cnt;
        if (r) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_cnt = 0; m_lvl = 1'b0; m_prs = 1'b0; m_rpt = 0; m_run = 1'b0;
            return;
        end
        raw = ~m_s2;
        m_s2 = m_s1;
        m_s1 = pin;
        prev_lvl = m_lvl;
        prev_cnt = m_cnt;
        if (raw != m_lvl) begin
            m_cnt++;
            if (m_cnt == DEB) begin
                m_lvl = raw;
                m_cnt = 0;
            end
        end else begin
            m_cnt = 0;
        end
        m_prs = m_lvl & ~prev_lvl;
`ifdef KEY_AUTOREPEAT_EN
        if (m_prs || !m_lvl) begin
            m_rpt = 0; m_run = 1'b0;
        end else if (prev_lvl && prev_cnt == 0 && raw) begin
            m_rpt++;
            if (m_rpt == (m_run ? RPER : RDLY)) begin
                m_prs = 1'b1; m_rpt = 0; m_run = 1'b1;
            end
        end
`else
        if (prev_cnt < 0) m_rpt = 0;
`endif
    endtask

    task automatic tick(input logic pin, input logic r);
        @(negedge clk);
        key_bus.in = pin;
        rst = r;
        @(posedge clk);
        model_step(pin, r);
        #1;
        check("level", key_bus.level, m_lvl);
        check("press", key_bus.press, m_prs);
        if (key_bus.press === 1'b1) press_seen++;
    endtask

    initial begin
        key_bus.in = 1'b1;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("reset_level", key_bus.level, 1'b0);
        check("reset_press", key_bus.press, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0);

        // Clean press: edges counted from the 1->0 change.
        for (int k = 1; k <= 8; k++) begin
            tick(1'b0, 1'b0);
            if (k == 5) check("clean_lvl5", key_bus.level, 1'b0);
            if (k == 6) begin
                check("clean_lvl6", key_bus.level, 1'b1);
                check("clean_prs6", key_bus.press, 1'b1);
            end
            if (k == 7) check("clean_prs7", key_bus.press, 1'b0);
        end

        // Release from held.
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0);
            if (k == 5) check("rel_lvl5", key_bus.level, 1'b1);
            if (k == 6) check("rel_lvl6", key_bus.level, 1'b0);
            check("rel_noprs", key_bus.press, 1'b0);
        end

        // Bounce 0,1,0,1 then hold 0: final edge is tick 5.
        press_seen = 0;
        for (int k = 1; k <= 14; k++) begin
            tick((k == 2 || k == 4) ? 1'b1 : 1'b0, 1'b0);
            if (k == 9)  check("bounce_lvl9", key_bus.level, 1'b0);
            if (k == 10) check("bounce_lvl10", key_bus.level, 1'b1);
        end
`ifndef KEY_AUTOREPEAT_EN
        check("bounce_presses", press_seen, 1);
`endif
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0);

        // Glitch of 3 low samples.
        for (int k = 1; k <= 12; k++) begin
            tick((k <= 3) ? 1'b0 : 1'b1, 1'b0);
            check("glitch_lvl", key_bus.level, 1'b0);
            check("glitch_prs", key_bus.press, 1'b0);
        end

        // Reset while held.
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b0);
        check("pre_rst_lvl", key_bus.level, 1'b1);
        tick(1'b0, 1'b1);
        check("midrst_lvl", key_bus.level, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            tick(1'b0, 1'b0);
            if (j == 5) check("post_rst_lvl5", key_bus.level, 1'b0);
            if (j == 6) begin
                check("post_rst_lvl6", key_bus.level, 1'b1);
                check("post_rst_prs6", key_bus.press, 1'b1);
            end
        end
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0);

`ifdef KEY_AUTOREPEAT_EN
        for (int k = 1; k <= 30; k++) begin
            tick(1'b0, 1'b0);
            check("rpt_prs", key_bus.press,
                  (k == 6 || k == 16 || k == 19 || k == 22 || k == 25 || k == 28) ? 1'b1 : 1'b0);
        end
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0);
`endif

        // Random runs of held levels with occasional resets.
        for (int n = 0; n < 600; n++) begin
            logic v;
            int   len;
            v = 1'($urandom_range(0, 1));
            len = $urandom_range(1, (n % 3 == 0) ? 40 : 7);
            for (int k = 0; k < len; k++) tick(v, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
